// File: rtl/lsu_dmem_wait_if.sv
// rtl/lsu_dmem_wait_if.sv - request/response bus between the pipeline and the load/store unit
//
// Signals:
//   req_valid/req_ready     request handshake (accepted when both are high at a rising edge)
//   req_we                  1 = store, 0 = load
//   req_funct3              RISC-V funct3 of the access
//   req_addr                byte address
//   req_wdata               store data, right-aligned
//   resp_valid              one-cycle response pulse
//   resp_rdata              extended load data (0 for stores and errors)
//   resp_err                misaligned or illegal access, qualified by resp_valid
// Modports: master = pipeline side, slave = load/store unit side.

interface lsu_dmem_wait_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_dmem_wait.sv
// rtl/lsu_dmem_wait.sv - load/store unit with byte-addressable data memory and fixed wait states
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   bus      lsu_dmem_wait_if.slave request/response bus
//   stall    high while an accepted access has not yet responded
//   wr       trace: store committed this cycle
//   rd       trace: load completed this cycle
//   addr     trace: byte address of the completing access
//   wr_data  trace: merged memory word written by a store
//   rd_data  trace: extended load result

module lsu_dmem_wait #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    lsu_dmem_wait_if.slave    bus,
    output logic              stall,
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int WORDS = 2 ** (ADDR_W - 2);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic              cap_we;
    logic [2:0]        cap_f3;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    // Word-organised storage; byte lanes are selected by the low address bits.
    logic [DATA_W-1:0] mem [0:WORDS-1];

    logic              legal;
    logic              misaligned;
    logic              err;
    logic              in_resp;
    logic              ok_resp;
    logic [DATA_W-1:0] cur_word;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_value;
    logic [DATA_W-1:0] new_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            cap_we    <= 1'b0;
            cap_f3    <= 3'd0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        cap_we    <= bus.req_we;
                        cap_f3    <= bus.req_funct3;
                        cap_addr  <= bus.req_addr;
                        cap_wdata <= bus.req_wdata;
                        if (LATENCY == 1) begin
                            state <= ST_RESP;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= 3'(LATENCY - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd1) begin
                        state <= ST_RESP;
                        cnt   <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // funct3[1:0] encodes the access size, funct3[2] selects zero-extension.
    always_comb begin
        legal = 1'b0;
        if (cap_we) begin
            legal = (cap_f3 == 3'b000) || (cap_f3 == 3'b001) || (cap_f3 == 3'b010);
        end else begin
            legal = (cap_f3 == 3'b000) || (cap_f3 == 3'b001) || (cap_f3 == 3'b010) ||
                    (cap_f3 == 3'b100) || (cap_f3 == 3'b101);
        end
        misaligned = ((cap_f3[1:0] == 2'b01) && cap_addr[0]) ||
                     ((cap_f3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
        err = !legal || misaligned;
    end

    assign in_resp  = (state == ST_RESP);
    assign ok_resp  = in_resp && !err;
    assign cur_word = mem[cap_addr[ADDR_W-1:2]];

    always_comb begin
        ld_byte  = cur_word[{cap_addr[1:0], 3'b000} +: 8];
        ld_half  = cap_addr[1] ? cur_word[31:16] : cur_word[15:0];
        ld_value = cur_word;
        case (cap_f3[1:0])
            2'b00:   ld_value = cap_f3[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_value = cap_f3[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_value = cur_word;
        endcase
    end

    // Read-modify-write merge: only the addressed lanes take store data.
    always_comb begin
        new_word = cur_word;
        case (cap_f3[1:0])
            2'b00:   new_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
            2'b01:   new_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
            default: new_word = cap_wdata;
        endcase
    end

    // State is reset asynchronously, so a reset during RESP suppresses this commit.
    always_ff @(posedge clk) begin
        if (ok_resp && cap_we) begin
            mem[cap_addr[ADDR_W-1:2]] <= new_word;
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = in_resp;
    assign bus.resp_err   = in_resp && err;
    assign bus.resp_rdata = (ok_resp && !cap_we) ? ld_value : '0;

    assign stall   = (state != ST_IDLE);
    assign wr      = ok_resp && cap_we;
    assign rd      = ok_resp && !cap_we;
    assign addr    = ok_resp ? cap_addr : '0;
    assign wr_data = (ok_resp && cap_we) ? new_word : '0;
    assign rd_data = (ok_resp && !cap_we) ? ld_value : '0;
endmodule

// File: tb/tb_lsu_dmem_wait.sv
// tb/tb_lsu_dmem_wait.sv - directed self-checking bench for lsu_dmem_wait

module tb_lsu_dmem_wait;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    lsu_dmem_wait_if #(.ADDR_W(9), .DATA_W(32)) b2 ();
    lsu_dmem_wait_if #(.ADDR_W(9), .DATA_W(32)) b3 ();

    logic        stall2, wr2, rd2, stall3, wr3, rd3;
    logic [8:0]  addr2, addr3;
    logic [31:0] wr_data2, rd_data2, wr_data3, rd_data3;

    lsu_dmem_wait #(.DATA_W(32), .ADDR_W(9), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2), .stall(stall2), .wr(wr2), .rd(rd2),
        .addr(addr2), .wr_data(wr_data2), .rd_data(rd_data2)
    );

    lsu_dmem_wait #(.DATA_W(32), .ADDR_W(9), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .bus(b3), .stall(stall3), .wr(wr3), .rd(rd3),
        .addr(addr3), .wr_data(wr_data3), .rd_data(rd_data3)
    );

    int errs = 0;
    int checks = 0;

    int          o_lat;
    logic        o_err, o_wr, o_rd;
    logic [8:0]  o_addr;
    logic [31:0] o_rdata, o_wrdata, o_rddata;

    // Issue one request on the LATENCY=2 unit and capture its response cycle.
    task automatic run2(input logic we, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_we = we; b2.req_funct3 = f3; b2.req_addr = a; b2.req_wdata = wd;
        @(negedge clk);
        b2.req_valid = 1'b0;
        n = 1;
        while (!b2.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        o_lat = n; o_err = b2.resp_err; o_rdata = b2.resp_rdata; o_wr = wr2; o_rd = rd2;
        o_addr = addr2; o_wrdata = wr_data2; o_rddata = rd_data2;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (b2.req_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%0b exp=1", b2.req_ready); end
        checks++; if (b2.resp_valid !== 1'b0) begin errs++; $display("FAIL rst_resp_valid got=%0b exp=0", b2.resp_valid); end
        checks++; if ({stall2, wr2, rd2, b2.resp_err} !== 4'b0) begin errs++; $display("FAIL rst_flags got=%b exp=0000", {stall2, wr2, rd2, b2.resp_err}); end
        checks++; if ({addr2, wr_data2, rd_data2, b2.resp_rdata} !== 105'd0) begin errs++; $display("FAIL rst_data got=%h exp=0", {addr2, wr_data2, rd_data2, b2.resp_rdata}); end
        checks++; if (b3.req_ready !== 1'b1 || stall3 !== 1'b0) begin errs++; $display("FAIL rst_dut3 got=%b exp=10", {b3.req_ready, stall3}); end
        reset = 1'b1;
    endtask

    task automatic test_word_roundtrip;
        run2(1'b1, 3'b010, 9'h010, 32'hDEADBEEF);
        checks++; if (o_lat !== 2) begin errs++; $display("FAIL sw_latency got=%0d exp=2", o_lat); end
        checks++; if (o_wr !== 1'b1 || o_rd !== 1'b0 || o_err !== 1'b0) begin errs++; $display("FAIL sw_flags got=%b exp=100", {o_wr, o_rd, o_err}); end
        checks++; if (o_wrdata !== 32'hDEADBEEF) begin errs++; $display("FAIL sw_wr_data got=%h exp=deadbeef", o_wrdata); end
        checks++; if (o_addr !== 9'h010 || o_rdata !== 32'h0) begin errs++; $display("FAIL sw_addr_rdata got=%h/%h exp=010/0", o_addr, o_rdata); end
        run2(1'b0, 3'b010, 9'h010, 32'h0);
        checks++; if (o_lat !== 2) begin errs++; $display("FAIL lw_latency got=%0d exp=2", o_lat); end
        checks++; if (o_rdata !== 32'hDEADBEEF || o_rddata !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_data got=%h/%h exp=deadbeef", o_rdata, o_rddata); end
        checks++; if (o_rd !== 1'b1 || o_wr !== 1'b0 || o_err !== 1'b0) begin errs++; $display("FAIL lw_flags got=%b exp=010", {o_rd, o_wr, o_err}); end
    endtask

    task automatic test_extension;
        run2(1'b0, 3'b000, 9'h013, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFFFDE) begin errs++; $display("FAIL lb got=%h exp=ffffffde", o_rdata); end
        run2(1'b0, 3'b100, 9'h013, 32'h0);
        checks++; if (o_rdata !== 32'h000000DE) begin errs++; $display("FAIL lbu got=%h exp=000000de", o_rdata); end
        run2(1'b0, 3'b001, 9'h010, 32'h0);
        checks++; if (o_rdata !== 32'hFFFFBEEF) begin errs++; $display("FAIL lh got=%h exp=ffffbeef", o_rdata); end
        run2(1'b0, 3'b101, 9'h012, 32'h0);
        checks++; if (o_rdata !== 32'h0000DEAD) begin errs++; $display("FAIL lhu got=%h exp=0000dead", o_rdata); end
    endtask

    task automatic test_partial_store;
        run2(1'b1, 3'b000, 9'h011, 32'h00000055);
        checks++; if (o_wrdata !== 32'hDEAD55EF || o_wr !== 1'b1) begin errs++; $display("FAIL sb_merge got=%h/%b exp=dead55ef/1", o_wrdata, o_wr); end
        run2(1'b0, 3'b010, 9'h010, 32'h0);
        checks++; if (o_rdata !== 32'hDEAD55EF) begin errs++; $display("FAIL sb_readback got=%h exp=dead55ef", o_rdata); end
        run2(1'b1, 3'b001, 9'h012, 32'h9999CAFE);
        checks++; if (o_wrdata !== 32'hCAFE55EF || o_addr !== 9'h012) begin errs++; $display("FAIL sh_merge got=%h/%h exp=cafe55ef/012", o_wrdata, o_addr); end
        run2(1'b0, 3'b010, 9'h010, 32'h0);
        checks++; if (o_rdata !== 32'hCAFE55EF) begin errs++; $display("FAIL sh_readback got=%h exp=cafe55ef", o_rdata); end
    endtask

    task automatic test_errors;
        run2(1'b0, 3'b010, 9'h012, 32'h0);
        checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_rd !== 1'b0) begin errs++; $display("FAIL lw_misaligned got=%b/%h/%b exp=1/0/0", o_err, o_rdata, o_rd); end
        run2(1'b1, 3'b001, 9'h011, 32'h00001111);
        checks++; if (o_err !== 1'b1 || o_wr !== 1'b0 || o_wrdata !== 32'h0) begin errs++; $display("FAIL sh_misaligned got=%b/%b/%h exp=1/0/0", o_err, o_wr, o_wrdata); end
        run2(1'b0, 3'b010, 9'h010, 32'h0);
        checks++; if (o_rdata !== 32'hCAFE55EF) begin errs++; $display("FAIL misaligned_no_write got=%h exp=cafe55ef", o_rdata); end
        run2(1'b0, 3'b011, 9'h010, 32'h0);
        checks++; if (o_err !== 1'b1 || o_rd !== 1'b0) begin errs++; $display("FAIL load_f3_011 got=%b/%b exp=1/0", o_err, o_rd); end
        run2(1'b1, 3'b100, 9'h010, 32'h0);
        checks++; if (o_err !== 1'b1 || o_wr !== 1'b0) begin errs++; $display("FAIL store_f3_100 got=%b/%b exp=1/0", o_err, o_wr); end
        run2(1'b0, 3'b010, 9'h010, 32'h0);
        checks++; if (o_rdata !== 32'hCAFE55EF || o_err !== 1'b0) begin errs++; $display("FAIL illegal_no_write got=%h/%b exp=cafe55ef/0", o_rdata, o_err); end
    endtask

    task automatic test_back_to_back;
        int          acc [2];
        int          resp_c [2];
        int          n_acc, n_resp, stall_cnt, ready0_cnt;
        logic [31:0] r_wdata0, r_rdata1;
        logic [8:0]  r_addr0;
        logic        r_wr0;
        n_acc = 0; n_resp = 0; stall_cnt = 0; ready0_cnt = 0;
        acc[0] = -1; acc[1] = -1; resp_c[0] = -1; resp_c[1] = -1;
        r_wdata0 = '0; r_rdata1 = '0; r_addr0 = '0; r_wr0 = 1'b0;
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_funct3 = 3'b010;
        b3.req_addr = 9'h040; b3.req_wdata = 32'h11111111;
        for (int c = 0; c < 12; c++) begin
            if (n_acc == 2) b3.req_valid = 1'b0;
            if (b3.req_valid && b3.req_ready && n_acc < 2) begin
                acc[n_acc] = c;
                n_acc++;
            end
            if (c >= 1 && c <= 3) begin
                if (stall3) stall_cnt++;
                if (!b3.req_ready) ready0_cnt++;
            end
            if (b3.resp_valid && n_resp < 2) begin
                resp_c[n_resp] = c;
                if (n_resp == 0) begin r_wr0 = wr3; r_wdata0 = wr_data3; r_addr0 = addr3; end
                else r_rdata1 = b3.resp_rdata;
                n_resp++;
            end
            if (c == 1) begin
                b3.req_we = 1'b0; b3.req_wdata = 32'hFFFFFFFF;
            end
            @(negedge clk);
        end
        b3.req_valid = 1'b0;
        checks++; if (acc[0] !== 0 || acc[1] !== 4) begin errs++; $display("FAIL b2b_accept got=%0d,%0d exp=0,4", acc[0], acc[1]); end
        checks++; if (resp_c[0] !== 3 || resp_c[1] !== 7) begin errs++; $display("FAIL b2b_resp_cycle got=%0d,%0d exp=3,7", resp_c[0], resp_c[1]); end
        checks++; if (stall_cnt !== 3 || ready0_cnt !== 3) begin errs++; $display("FAIL b2b_stall_ready got=%0d,%0d exp=3,3", stall_cnt, ready0_cnt); end
        checks++; if (r_wr0 !== 1'b1 || r_wdata0 !== 32'h11111111 || r_addr0 !== 9'h040) begin errs++; $display("FAIL b2b_captured got=%b/%h/%h exp=1/11111111/040", r_wr0, r_wdata0, r_addr0); end
        checks++; if (r_rdata1 !== 32'h11111111) begin errs++; $display("FAIL b2b_load got=%h exp=11111111", r_rdata1); end
    endtask

    task automatic test_reset_abort;
        run2(1'b1, 3'b010, 9'h020, 32'hA5A5A5A5);
        @(negedge clk);
        b2.req_valid = 1'b1; b2.req_we = 1'b1; b2.req_funct3 = 3'b010;
        b2.req_addr = 9'h020; b2.req_wdata = 32'h12345678;
        @(negedge clk);
        b2.req_valid = 1'b0;
        checks++; if (stall2 !== 1'b1) begin errs++; $display("FAIL abort_in_wait got=%0b exp=1", stall2); end
        reset = 1'b0;
        #1;
        checks++; if (stall2 !== 1'b0 || b2.req_ready !== 1'b1 || b2.resp_valid !== 1'b0) begin errs++; $display("FAIL abort_immediate got=%b exp=010", {stall2, b2.req_ready, b2.resp_valid}); end
        @(negedge clk);
        checks++; if (b2.resp_valid !== 1'b0 || wr2 !== 1'b0) begin errs++; $display("FAIL abort_no_resp got=%b exp=00", {b2.resp_valid, wr2}); end
        @(negedge clk);
        reset = 1'b1;
        run2(1'b0, 3'b010, 9'h020, 32'h0);
        checks++; if (o_rdata !== 32'hA5A5A5A5) begin errs++; $display("FAIL abort_no_commit got=%h exp=a5a5a5a5", o_rdata); end
    endtask

    initial begin
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.req_funct3 = 3'b000; b2.req_addr = '0; b2.req_wdata = '0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_funct3 = 3'b000; b3.req_addr = '0; b3.req_wdata = '0;
        test_reset;
        test_word_roundtrip;
        test_extension;
        test_partial_store;
        test_errors;
        test_back_to_back;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
